load_access_ctrl: RTL and testbench

- Sequences every MIPS load (LB, LH, LWL, LW, LBU, LHU, LWR) between the core and the data memory's Avalon-style read port.
- Issues a word-aligned bus read with the correct byteenable and waits out waitrequest.
- Selects the addressed byte or half-word lane, then sign- or zero-extends it, or merges with the old rt value for LWL/LWR.
- Returns the 32-bit write-back value, or an error for a misaligned access, bad op or bus timeout. Sits between the execute stage and the data memory interface.

---
 rtl/load_access_ctrl.sv | 139 +++++++++++++
 tb/tb_load_access_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/load_access_ctrl.sv
// Load sequencer between the execute stage and the data memory read port:
// issues one aligned bus read per load, then extracts, extends or merges the result.
//
// state   | meaning
// IDLE    | ready for a request; alignment/op checked on accept
// READ    | bus read asserted, waiting out waitrequest
// CAPTURE | readdata valid; result computed into result_q
// DONE    | one-cycle good response
// ERR     | one-cycle error response (misaligned, illegal op, timeout)
module load_access_ctrl #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rt,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_DONE, S_ERR} state_t;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LWL = 3'b010;
  localparam logic [2:0] OP_LW  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_LWR = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT    = CW'(WAIT_LIMIT);
  localparam logic [CW-1:0] LIMIT_M1 = CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  state_t        state, state_nxt;
  logic [31:0]   addr_q, rt_q, result_q, result_nxt, shifted;
  logic [2:0]    op_q;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    o;
  logic [4:0]    sh_r, sh_l;
  logic [3:0]    be;
  logic          req_bad, timeout;

  assign o    = addr_q[1:0];
  assign sh_r = {o, 3'b000};
  assign sh_l = {2'd3 - o, 3'b000};

  assign req_bad = (req_op == OP_ILL)
                 | (((req_op == OP_LH) | (req_op == OP_LHU)) & req_addr[0])
                 | ((req_op == OP_LW) & (req_addr[1:0] != 2'b00));

  // Fires on the WAIT_LIMIT-th consecutive stalled cycle, so read is high exactly WAIT_LIMIT cycles.
  assign timeout = (WAIT_LIMIT > 0) && avm_waitrequest && (wait_cnt == LIMIT_M1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      op_q     <= '0;
      rt_q     <= '0;
      wait_cnt <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req_valid) begin
        addr_q <= req_addr;
        op_q   <= req_op;
        rt_q   <= req_rt;
      end
      if (state != S_READ)
        wait_cnt <= '0;
      else if (avm_waitrequest && wait_cnt != LIMIT)
        wait_cnt <= wait_cnt + 1'b1;
      if (state == S_CAPTURE)
        result_q <= result_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (req_valid) state_nxt = req_bad ? S_ERR : S_READ;
      S_READ:    if (!avm_waitrequest) state_nxt = S_CAPTURE;
                 else if (timeout)    state_nxt = S_ERR;
      S_CAPTURE: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      S_ERR:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    be = 4'b0000;
    case (op_q)
      OP_LB, OP_LBU: be = 4'b0001 << o;
      OP_LH, OP_LHU: be = 4'b0011 << o;
      OP_LW:         be = 4'b1111;
      OP_LWL:        be = (4'b0001 << o) | ((4'b0001 << o) - 4'b0001);
      OP_LWR:        be = 4'b1111 << o;
      default:       be = 4'b0000;
    endcase
  end

  always_comb begin
    shifted    = avm_readdata >> sh_r;
    result_nxt = '0;
    case (op_q)
      OP_LB:   result_nxt = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  result_nxt = {24'h0, shifted[7:0]};
      OP_LH:   result_nxt = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  result_nxt = {16'h0, shifted[15:0]};
      OP_LW:   result_nxt = avm_readdata;
      OP_LWL:  result_nxt = (avm_readdata << sh_l) | (rt_q & ~(32'hFFFF_FFFF << sh_l));
      OP_LWR:  result_nxt = shifted | (rt_q & ~(32'hFFFF_FFFF >> sh_r));
      default: result_nxt = '0;
    endcase
  end

  always_comb begin
    req_ready      = (state == S_IDLE);
    avm_read       = (state == S_READ);
    avm_address    = (state == S_READ) ? {addr_q[31:2], 2'b00} : 32'h0;
    avm_byteenable = (state == S_READ) ? be : 4'b0000;
    resp_valid     = (state == S_DONE) || (state == S_ERR);
    resp_err       = (state == S_ERR);
    resp_data      = (state == S_DONE) ? result_q : 32'h0;
  end

endmodule

// File: tb/tb_load_access_ctrl.sv
// Directed bench for load_access_ctrl: each load is stepped cycle by cycle and
// checked against hand-computed bus signals, latency and results.
module tb_load_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_op;
  logic [31:0] req_rt;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  int n_vec = 0;
  int n_err = 0;

  load_access_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_op(req_op), .req_rt(req_rt),
    .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rt);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_rt    = rt;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEEF;
    req_rt    = 32'h5A5A_5A5A;
  endtask

  // Good load: accept, `waits` stall cycles, capture, one-cycle response, back to ready.
  task automatic load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] rt, input logic [31:0] rdata, input int waits,
                      input logic [3:0] exp_be, input logic [31:0] exp_data);
    issue(op, addr, rt);
    for (int i = 0; i < waits; i++) begin
      avm_waitrequest = 1'b1;
      chk({tag, ".stall_read"}, 32'(avm_read), 32'd1);
      chk({tag, ".stall_addr"}, avm_address, {addr[31:2], 2'b00});
      chk({tag, ".stall_be"}, 32'(avm_byteenable), 32'(exp_be));
      @(negedge clk);
    end
    avm_waitrequest = 1'b0;
    chk({tag, ".read"}, 32'(avm_read), 32'd1);
    chk({tag, ".addr"}, avm_address, {addr[31:2], 2'b00});
    chk({tag, ".be"}, 32'(avm_byteenable), 32'(exp_be));
    chk({tag, ".busy"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    avm_readdata = rdata;
    chk({tag, ".cap_read"}, 32'(avm_read), 32'd0);
    chk({tag, ".cap_valid"}, 32'(resp_valid), 32'd0);
    @(negedge clk);
    avm_readdata = 32'h0BAD_0BAD;
    chk({tag, ".valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".err"}, 32'(resp_err), 32'd0);
    chk({tag, ".data"}, resp_data, exp_data);
    @(negedge clk);
    chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
    chk({tag, ".valid_after"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic bad(input string tag, input logic [2:0] op, input logic [31:0] addr);
    issue(op, addr, 32'hFFFF_FFFF);
    chk({tag, ".valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".err"}, 32'(resp_err), 32'd1);
    chk({tag, ".data"}, resp_data, 32'h0);
    chk({tag, ".no_read"}, 32'(avm_read), 32'd0);
    @(negedge clk);
    chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
    chk({tag, ".valid_after"}, 32'(resp_valid), 32'd0);
    chk({tag, ".no_read_after"}, 32'(avm_read), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_op = '0;
    req_rt = '0;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    #12;
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.read", 32'(avm_read), 32'd0);
    chk("rst.addr", avm_address, 32'h0);
    chk("rst.be", 32'(avm_byteenable), 32'd0);
    chk("rst.valid", 32'(resp_valid), 32'd0);
    chk("rst.err", 32'(resp_err), 32'd0);
    chk("rst.data", resp_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    load("lb3",   3'b000, 32'h1003, 32'h0, 32'h80FF1234, 0, 4'b1000, 32'hFFFFFF80);
    load("lbu3",  3'b100, 32'h1003, 32'h0, 32'h80FF1234, 0, 4'b1000, 32'h00000080);
    load("lb1",   3'b000, 32'h1001, 32'h0, 32'h80FF1234, 0, 4'b0010, 32'h00000012);
    load("lh_w3", 3'b001, 32'h2002, 32'h0, 32'h7AEC0000, 3, 4'b1100, 32'h00007AEC);
    load("lh_neg",3'b001, 32'h2002, 32'h0, 32'hC84D0000, 1, 4'b1100, 32'hFFFFC84D);
    load("lhu",   3'b101, 32'h2002, 32'h0, 32'hC84D0000, 0, 4'b1100, 32'h0000C84D);
    load("lh0",   3'b001, 32'h2000, 32'h0, 32'hC84D9123, 0, 4'b0011, 32'hFFFF9123);
    load("lwl1",  3'b010, 32'h0001, 32'h11223344, 32'hAABBCCDD, 0, 4'b0011, 32'hCCDD3344);
    load("lwr1",  3'b110, 32'h0001, 32'h11223344, 32'hAABBCCDD, 0, 4'b1110, 32'h11AABBCC);
    load("lwl3",  3'b010, 32'h0003, 32'h11223344, 32'hAABBCCDD, 0, 4'b1111, 32'hAABBCCDD);
    load("lwl0",  3'b010, 32'h0000, 32'h11223344, 32'hAABBCCDD, 0, 4'b0001, 32'hDD223344);
    load("lwr0",  3'b110, 32'h0000, 32'h11223344, 32'hAABBCCDD, 0, 4'b1111, 32'hAABBCCDD);
    load("lwr3",  3'b110, 32'h0003, 32'h11223344, 32'hAABBCCDD, 2, 4'b1000, 32'h112233AA);
    load("lw",    3'b011, 32'h0010, 32'h0, 32'h12345678, 0, 4'b1111, 32'h12345678);

    bad("lw_mis",  3'b011, 32'h0006);
    bad("lh_mis",  3'b001, 32'h0005);
    bad("lhu_mis", 3'b101, 32'h0003);
    bad("ill",     3'b111, 32'h0000);

    // Stuck waitrequest: read held exactly four cycles, then error.
    avm_waitrequest = 1'b1;
    issue(3'b011, 32'h0040, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("tmo.read", 32'(avm_read), 32'd1);
      chk("tmo.no_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    chk("tmo.read_dropped", 32'(avm_read), 32'd0);
    chk("tmo.valid", 32'(resp_valid), 32'd1);
    chk("tmo.err", 32'(resp_err), 32'd1);
    chk("tmo.data", resp_data, 32'h0);
    avm_waitrequest = 1'b0;
    @(negedge clk);
    chk("tmo.ready_after", 32'(req_ready), 32'd1);
    load("lw_after_tmo", 3'b011, 32'h0044, 32'h0, 32'hCAFEF00D, 0, 4'b1111, 32'hCAFEF00D);

    // Asynchronous reset in the middle of a stalled read.
    avm_waitrequest = 1'b1;
    issue(3'b011, 32'h0080, 32'h0);
    chk("rstmid.read_before", 32'(avm_read), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rstmid.read_async", 32'(avm_read), 32'd0);
    chk("rstmid.ready_async", 32'(req_ready), 32'd1);
    @(negedge clk);
    avm_waitrequest = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rstmid.no_valid", 32'(resp_valid), 32'd0);
      chk("rstmid.ready", 32'(req_ready), 32'd1);
      @(negedge clk);
    end
    load("lw_after_rst", 3'b011, 32'h0084, 32'h0, 32'h0F1E2D3C, 0, 4'b1111, 32'h0F1E2D3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
